// File: rtl/ram_pkg.sv
// Shared definitions for the 16x8 program/data RAM: geometry defaults, clear value and FSM states.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned RAM_DEPTH  = 16;

  localparam logic [7:0] CLEAR_VALUE = 8'h00;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Storage for the RAM: one synchronous write port and one asynchronous read port, no reset.
module ram_array #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_16x8.sv
// 16x8 CPU RAM with bus read/write, a hardware clear after reset and a
// handshaked sequential program loader.
module ram_16x8
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ram_in,
  input  logic              ram_out,
  output logic [DATA_W-1:0] data_out,
  output logic              out_en,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              prog_mode_q;
  logic              prog_done_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // State, load pointer, prog_mode edge detector and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      prog_mode_q <= 1'b0;
      prog_done   <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      prog_mode_q <= prog_mode;
      prog_done   <= prog_done_d;
    end
  end

  // Next state, write-port mux and combinational handshake/bus outputs
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    prog_done_d = 1'b0;
    we          = 1'b0;
    waddr       = addr;
    wdata       = bus_in;
    out_en      = 1'b0;
    prog_ready  = 1'b0;
    busy        = 1'b1;

    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr;
        wdata = DATA_W'(CLEAR_VALUE);
        ptr_d = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy   = 1'b0;
        out_en = ram_out;
        we     = ram_in;
        // Only a fresh rising edge starts a load; a held level does not
        if (prog_mode && !prog_mode_q) begin
          state_d = PROG;
          ptr_d   = '0;
        end
      end

      PROG: begin
        prog_ready = 1'b1;
        waddr      = ptr;
        wdata      = prog_data;
        if (prog_valid) begin
          we    = 1'b1;
          ptr_d = ptr + ADDR_W'(1);
        end
        if (prog_valid && ptr == LAST_ADDR) begin
          ptr_d       = '0;
          prog_done_d = 1'b1;
          state_d     = RUN;
        end else if (!prog_mode) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (data_out)
  );

endmodule
